// File: rtl/vx_itr_timer.sv
// Periodic interrupt source: programmable tick counter feeding one valid/ready
// request lane per core, with per-lane request/service tracking and overrun flags.
module vx_itr_timer #(
    parameter int NUM_CORES = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_wr_valid,
    input  logic [1:0]           cfg_wr_addr,
    input  logic [31:0]          cfg_wr_data,
    output logic [NUM_CORES-1:0] itr_valid,
    input  logic [NUM_CORES-1:0] itr_ready,
    input  logic [NUM_CORES-1:0] itr_done,
    output logic [NUM_CORES-1:0] overrun,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] ADDR_PERIOD  = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_OVR_CLR = 2'd3;

    logic [CNT_WIDTH-1:0]      r_period;
    logic [NUM_CORES-1:0]      r_mask;
    logic                      r_en;
    logic                      r_oneshot;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic [NUM_CORES-1:0][1:0] r_state;
    logic [NUM_CORES-1:0]      r_itr_valid;
    logic [NUM_CORES-1:0]      r_overrun;
    logic                      r_busy;

    logic                      w_wr_period;
    logic                      w_wr_mask;
    logic                      w_wr_ctrl;
    logic                      w_wr_ovr_clr;
    logic                      w_en_rise;
    logic                      w_cnt_restart;
    logic                      w_cnt_run;
    logic                      w_tick;
    logic [CNT_WIDTH-1:0]      w_cfg_period;
    logic [CNT_WIDTH-1:0]      w_period_m1;
    logic [CNT_WIDTH-1:0]      w_cnt_nxt;
    logic [NUM_CORES-1:0]      w_lane_tick;
    logic [NUM_CORES-1:0]      w_ovr_set;
    logic [NUM_CORES-1:0]      w_ovr_clr;
    logic [NUM_CORES-1:0]      w_overrun_nxt;
    logic [NUM_CORES-1:0][1:0] w_state_nxt;
    logic [NUM_CORES-1:0]      w_valid_nxt;
    logic                      w_busy_nxt;

    assign w_wr_period  = cfg_wr_valid && (cfg_wr_addr == ADDR_PERIOD);
    assign w_wr_mask    = cfg_wr_valid && (cfg_wr_addr == ADDR_MASK);
    assign w_wr_ctrl    = cfg_wr_valid && (cfg_wr_addr == ADDR_CTRL);
    assign w_wr_ovr_clr = cfg_wr_valid && (cfg_wr_addr == ADDR_OVR_CLR);
    assign w_cfg_period = CNT_WIDTH'(cfg_wr_data);

    // A PERIOD write or an enable edge restarts the count and beats any tick this cycle.
    assign w_en_rise     = w_wr_ctrl && cfg_wr_data[0] && !r_en;
    assign w_cnt_restart = w_wr_period || w_en_rise;
    assign w_cnt_run     = r_en && (r_period != '0);
    assign w_period_m1   = r_period - CNT_WIDTH'(1);
    assign w_tick        = w_cnt_run && (r_cnt == w_period_m1) && !w_cnt_restart;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_cnt_restart || w_tick) begin
            w_cnt_nxt = '0;
        end else if (w_cnt_run) begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
    end

    assign w_lane_tick = {NUM_CORES{w_tick}} & r_mask;

    // A tick landing on a lane that is still requesting or in service is dropped and flagged.
    always_comb begin
        w_state_nxt = r_state;
        w_ovr_set   = '0;
        w_valid_nxt = '0;
        w_busy_nxt  = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            case (r_state[i])
                ST_IDLE: begin
                    if (w_lane_tick[i]) w_state_nxt[i] = ST_REQ;
                end
                ST_REQ: begin
                    if (itr_ready[i]) w_state_nxt[i] = ST_SERVICE;
                    if (w_lane_tick[i]) w_ovr_set[i] = 1'b1;
                end
                ST_SERVICE: begin
                    if (itr_done[i]) begin
                        w_state_nxt[i] = w_lane_tick[i] ? ST_REQ : ST_IDLE;
                    end else if (w_lane_tick[i]) begin
                        w_ovr_set[i] = 1'b1;
                    end
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
            w_valid_nxt[i] = (w_state_nxt[i] == ST_REQ);
            if (w_state_nxt[i] != ST_IDLE) w_busy_nxt = 1'b1;
        end
    end

    assign w_ovr_clr     = w_wr_ovr_clr ? cfg_wr_data[NUM_CORES-1:0] : '0;
    assign w_overrun_nxt = (r_overrun & ~w_ovr_clr) | w_ovr_set;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_period    <= '0;
            r_mask      <= '0;
            r_en        <= 1'b0;
            r_oneshot   <= 1'b0;
            r_cnt       <= '0;
            r_state     <= '0;
            r_itr_valid <= '0;
            r_overrun   <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_wr_period) r_period <= w_cfg_period;
            if (w_wr_mask)   r_mask   <= cfg_wr_data[NUM_CORES-1:0];
            if (w_wr_ctrl) begin
                r_en      <= cfg_wr_data[0];
                r_oneshot <= cfg_wr_data[1];
            end else if (w_tick && r_oneshot) begin
                r_en <= 1'b0;
            end
            r_cnt       <= w_cnt_nxt;
            r_state     <= w_state_nxt;
            r_itr_valid <= w_valid_nxt;
            r_overrun   <= w_overrun_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign itr_valid = r_itr_valid;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule

// File: tb/tb_vx_itr_timer.sv
// Directed bench for vx_itr_timer: periodic requests, backpressure, overrun,
// done/tick coincidence, one-shot, period rewrite and mid-operation reset.
module tb_vx_itr_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_wr_valid = 1'b0;
    logic [1:0]  cfg_wr_addr = 2'd0;
    logic [31:0] cfg_wr_data = 32'd0;
    logic [3:0]  itr_valid;
    logic [3:0]  itr_ready = 4'd0;
    logic [3:0]  itr_done = 4'd0;
    logic [3:0]  overrun;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    vx_itr_timer #(.NUM_CORES(4), .CNT_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr_valid (cfg_wr_valid),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .itr_valid    (itr_valid),
        .itr_ready    (itr_ready),
        .itr_done     (itr_done),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = addr;
        cfg_wr_data  = data;
        step();
        cfg_wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        itr_done = 4'd0;
        step();
        reset = 1'b1;
    endtask

    // CTRL write lands in cycle 0, so the bench is in cycle 1 afterwards.
    task automatic setup(input logic [31:0] period, input logic [31:0] mask, input logic [31:0] ctrl);
        wr(2'd0, period);
        wr(2'd1, mask);
        cyc = 0;
        wr(2'd2, ctrl);
    endtask

    initial begin
        // Reset state
        step();
        do_reset();
        chk("rst_valid", itr_valid, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_busy", busy, 0);

        // Basic periodic request: PERIOD=5, ticks at 5,10,15
        itr_ready = 4'b1111;
        setup(5, 4'b0001, 1);
        while (cyc <= 17) begin
            chk("t1_valid", itr_valid, (cyc == 6 || cyc == 11 || cyc == 16) ? 1 : 0);
            chk("t1_busy", busy, ((cyc >= 6 && cyc <= 8) || (cyc >= 11 && cyc <= 13) || cyc >= 16) ? 1 : 0);
            chk("t1_ovr", overrun, 0);
            itr_done = (cyc == 8 || cyc == 13) ? 4'b0001 : 4'b0000;
            step();
        end
        itr_done = 4'd0;

        // Backpressure: ready withheld until cycle 9
        do_reset();
        itr_ready = 4'b0000;
        setup(5, 4'b0001, 1);
        while (cyc <= 12) begin
            chk("t2_valid", itr_valid, (cyc >= 6 && cyc <= 9) ? 1 : 0);
            chk("t2_busy", busy, (cyc >= 6) ? 1 : 0);
            chk("t2_ovr", overrun, (cyc >= 11) ? 1 : 0);
            itr_ready = (cyc >= 9) ? 4'b1111 : 4'b0000;
            step();
        end

        // Overrun on lane 1, lane 0 serviced and re-requested
        do_reset();
        itr_ready = 4'b1111;
        setup(4, 4'b0011, 1);
        while (cyc <= 9) begin
            chk("t3_valid", itr_valid, (cyc == 5) ? 4'b0011 : (cyc == 9) ? 4'b0001 : 4'b0000);
            chk("t3_ovr", overrun, (cyc >= 9) ? 4'b0010 : 4'b0000);
            chk("t3_busy", busy, (cyc >= 5) ? 1 : 0);
            itr_done = (cyc == 7) ? 4'b0001 : 4'b0000;
            step();
        end
        itr_done = 4'd0;
        chk("t3_ovr_hold", overrun, 4'b0010);
        wr(2'd3, 4'b0010);
        chk("t3_ovr_clr", overrun, 4'b0000);
        step();
        wr(2'd3, 4'b0011);
        chk("t3_ovr_set_wins", overrun, 4'b0011);
        chk("t3_valid_13", itr_valid, 4'b0000);

        // itr_done in the exact tick cycle goes straight back to REQ
        do_reset();
        itr_ready = 4'b1111;
        setup(4, 4'b0001, 1);
        while (cyc <= 10) begin
            chk("t4_valid", itr_valid, (cyc == 5 || cyc == 9) ? 1 : 0);
            chk("t4_ovr", overrun, 0);
            chk("t4_busy", busy, (cyc >= 5) ? 1 : 0);
            itr_done = (cyc == 8) ? 4'b0001 : 4'b0000;
            step();
        end
        itr_done = 4'd0;

        // One-shot, then re-enable and rewrite PERIOD in a tick cycle
        do_reset();
        itr_ready = 4'b1111;
        setup(3, 4'b0001, 3);
        while (cyc <= 13) begin
            chk("t5_valid", itr_valid, (cyc == 4) ? 1 : 0);
            chk("t5_busy", busy, (cyc >= 4 && cyc <= 6) ? 1 : 0);
            itr_done = (cyc == 6) ? 4'b0001 : 4'b0000;
            step();
        end
        itr_done = 4'd0;
        while (cyc <= 25) begin
            chk("t5b_valid", itr_valid, (cyc == 24) ? 1 : 0);
            chk("t5b_busy", busy, (cyc >= 24) ? 1 : 0);
            cfg_wr_valid = (cyc == 14 || cyc == 17);
            cfg_wr_addr  = (cyc == 14) ? 2'd2 : 2'd0;
            cfg_wr_data  = (cyc == 14) ? 32'd1 : 32'd6;
            step();
        end
        cfg_wr_valid = 1'b0;

        // Reset while a request and an overrun are outstanding
        do_reset();
        itr_ready = 4'b0000;
        setup(3, 4'b0001, 1);
        while (cyc < 7) step();
        chk("t6_pre_valid", itr_valid, 1);
        chk("t6_pre_ovr", overrun, 1);
        chk("t6_pre_busy", busy, 1);
        reset = 1'b0;
        step();
        chk("t6_valid", itr_valid, 0);
        chk("t6_ovr", overrun, 0);
        chk("t6_busy", busy, 0);
        reset = 1'b1;
        itr_ready = 4'b1111;
        repeat (10) begin
            step();
            chk("t6_quiet_valid", itr_valid, 0);
            chk("t6_quiet_busy", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
